// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_pkg;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} axis_phase_e;
  typedef enum logic {IDLE, RUN} gen_state_e;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Each axis runs ACTIVE, front porch, SYNC, back porch in that order.
  function automatic axis_phase_e axis_phase(input int pos, input int active,
                                             input int fp, input int sync);
    if (pos < active)                 return PH_ACTIVE;
    else if (pos < active + fp)       return PH_FP;
    else if (pos < active + fp + sync) return PH_SYNC;
    else                              return PH_BP;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, phase decode, sync and terminal-count flags.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   TOTAL  = 800,
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter logic POL    = 1'b0,
  parameter int   W      = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         advance,
  input  logic         idle,
  output logic [W-1:0] pos,
  output logic         sync,
  output logic         active,
  output logic         tc
);

  logic [W-1:0] pos_d;
  axis_phase_e  phase_d;

  // Flags are decoded from the next position so they register alongside it.
  always_comb begin
    pos_d = pos;
    if (idle)
      pos_d = '0;
    else if (advance)
      pos_d = (pos == W'(TOTAL - 1)) ? '0 : pos + W'(1);
    phase_d = axis_phase(int'(pos_d), ACTIVE, FP, SYNC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos    <= '0;
      sync   <= ~POL;
      active <= 1'b0;
      tc     <= 1'b0;
    end else if (ce) begin
      pos    <= pos_d;
      sync   <= (!idle && phase_d == PH_SYNC) ? POL : ~POL;
      active <= !idle && (phase_d == PH_ACTIVE);
      tc     <= !idle && (pos_d == W'(TOTAL - 1));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable divider and
// frame-boundary run/stop control.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 11,
  parameter int FC_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             sof,
  output logic             eol,
  output logic [FC_W-1:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [DIV_W-1:0] div;
  gen_state_e       state, state_d;
  logic             h_tc, v_tc, h_act, v_act, frame_end;
  logic             start, h_adv, v_adv, idle_d;

  // pix_ce is the registered terminal count of the divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else begin
      pix_ce <= (div == DIV_W'(CLK_DIV - 1));
      div    <= (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);
    end
  end

  assign frame_end = h_tc & v_tc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (pix_ce && en)                state_d = RUN;
      RUN:  if (pix_ce && frame_end && !en)  state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // A fresh frame starts either from IDLE or by wrapping the last pixel.
  always_comb begin
    start  = 1'b0;
    h_adv  = 1'b0;
    v_adv  = 1'b0;
    idle_d = (state_d == IDLE);
    case (state)
      IDLE: start = pix_ce && en;
      RUN: begin
        h_adv = 1'b1;
        v_adv = h_tc;
        start = pix_ce && frame_end && en;
      end
      default: ;
    endcase
  end

  vga_axis_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC),
    .POL(HS_POL), .W(CNT_W)
  ) u_h (
    .clk(clk), .reset(reset), .ce(pix_ce), .advance(h_adv), .idle(idle_d),
    .pos(x), .sync(hsync), .active(h_act), .tc(h_tc)
  );

  vga_axis_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC),
    .POL(VS_POL), .W(CNT_W)
  ) u_v (
    .clk(clk), .reset(reset), .ce(pix_ce), .advance(v_adv), .idle(idle_d),
    .pos(y), .sync(vsync), .active(v_act), .tc(v_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sof       <= 1'b0;
      frame_cnt <= '0;
    end else if (pix_ce) begin
      sof <= start;
      if (start) frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

  assign de  = h_act & v_act;
  assign eol = h_tc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Two generator configurations checked every cycle against a flat pixel-index model.
module tb_vga_timing_gen;

  localparam int A_DIV = 3;
  localparam int A_HA = 16, A_HF = 4, A_HS = 6, A_HB = 5;
  localparam int A_VA = 10, A_VF = 2, A_VS = 3, A_VB = 4;
  localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
  localparam int B_DIV = 1;
  localparam int B_HA = 4, B_HF = 1, B_HS = 1, B_HB = 1;
  localparam int B_VA = 3, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, en_a, en_b;
  logic       ce_a, hs_a, vs_a, de_a, sof_a, eol_a;
  logic [5:0] x_a, y_a;
  logic [3:0] fc_a;
  logic       ce_b, hs_b, vs_b, de_b, sof_b, eol_b;
  logic [2:0] x_b, y_b;
  logic [1:0] fc_b;

  vga_timing_gen #(
    .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(6), .FC_W(4)
  ) dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .pix_ce(ce_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .x(x_a), .y(y_a), .sof(sof_a), .eol(eol_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(3), .FC_W(2)
  ) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .pix_ce(ce_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .x(x_b), .y(y_b), .sof(sof_b), .eol(eol_b), .frame_cnt(fc_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: a phase counter for pix_ce and one flat pixel index per frame.
  typedef struct {
    int ph;
    bit ce;
    bit run;
    int idx;
    int fc;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t m;
    m.ph = 0; m.ce = 1'b0; m.run = 1'b0; m.idx = 0; m.fc = 0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input bit en, input int div,
                                        input int total);
    model_t n = m;
    if (m.ce) begin
      if (!m.run) begin
        if (en) begin n.run = 1'b1; n.idx = 0; n.fc = m.fc + 1; end
      end else if (m.idx == total - 1) begin
        if (en) begin n.idx = 0; n.fc = m.fc + 1; end
        else n.run = 1'b0;
      end else begin
        n.idx = m.idx + 1;
      end
    end
    n.ph = (m.ph + 1) % div;
    n.ce = (n.ph == 0);
    return n;
  endfunction

  always @(posedge clk or posedge rst_a)
    if (rst_a) ma <= model_reset();
    else       ma <= model_step(ma, en_a, A_DIV, A_HT * A_VT);

  always @(posedge clk or posedge rst_b)
    if (rst_b) mb <= model_reset();
    else       mb <= model_step(mb, en_b, B_DIV, B_HT * B_VT);

  task automatic compareDut(input string who, input model_t m, input int ht, input int ha,
                            input int hf, input int hs, input int va, input int vf,
                            input int vs, input bit hpol, input bit vpol, input int fcmod,
                            input logic ce, input logic hsync, input logic vsync,
                            input logic de, input logic sof, input logic eol,
                            input int x, input int y, input int fc);
    int ex, ey;
    ex = m.run ? m.idx % ht : 0;
    ey = m.run ? m.idx / ht : 0;
    checkOutput({who, ".pix_ce"}, 32'(ce), 32'(m.ce));
    checkOutput({who, ".x"}, 32'(x), 32'(ex));
    checkOutput({who, ".y"}, 32'(y), 32'(ey));
    checkOutput({who, ".hsync"}, 32'(hsync),
                32'((m.run && ex >= ha + hf && ex < ha + hf + hs) ? hpol : !hpol));
    checkOutput({who, ".vsync"}, 32'(vsync),
                32'((m.run && ey >= va + vf && ey < va + vf + vs) ? vpol : !vpol));
    checkOutput({who, ".de"}, 32'(de), 32'(m.run && ex < ha && ey < va));
    checkOutput({who, ".sof"}, 32'(sof), 32'(m.run && m.idx == 0));
    checkOutput({who, ".eol"}, 32'(eol), 32'(m.run && ex == ht - 1));
    checkOutput({who, ".frame_cnt"}, 32'(fc), 32'(m.fc % fcmod));
  endtask

  bit checking = 1'b0;
  int cyc = 0, rise_a = 0, rise_b = 0, per_a = 0, per_b = 0, sof_b_cnt = 0;
  logic sof_a_prev = 1'b0, sof_b_prev = 1'b0;

  always @(negedge clk) begin
    if (checking) begin
      compareDut("A", ma, A_HT, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, 1'b0, 1'b0, 16,
                 ce_a, hs_a, vs_a, de_a, sof_a, eol_a, int'(x_a), int'(y_a), int'(fc_a));
      compareDut("B", mb, B_HT, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, 1'b1, 1'b1, 4,
                 ce_b, hs_b, vs_b, de_b, sof_b, eol_b, int'(x_b), int'(y_b), int'(fc_b));
    end
    cyc++;
    if (sof_a && !sof_a_prev) begin per_a = cyc - rise_a; rise_a = cyc; end
    if (sof_b && !sof_b_prev) begin per_b = cyc - rise_b; rise_b = cyc; sof_b_cnt++; end
    sof_a_prev = sof_a;
    sof_b_prev = sof_b;
  end

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) en_a = ~en_a;
      if ($urandom_range(0, 59) == 0)  en_b = ~en_b;
    end
  endtask

  initial begin
    int n;
    logic [3:0] fc_saved;
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    checkOutput("A.reset_hsync", 32'(hs_a), 32'(1));
    checkOutput("B.reset_vsync", 32'(vs_b), 32'(0));
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;

    // First pix_ce lands on the CLK_DIV-th edge after release.
    @(negedge clk);
    checkOutput("A.ce_edge1", 32'(ce_a), 32'(0));
    checkOutput("B.ce_edge1", 32'(ce_b), 32'(1));
    @(negedge clk);
    checkOutput("A.ce_edge2", 32'(ce_a), 32'(0));
    @(negedge clk);
    checkOutput("A.ce_edge3", 32'(ce_a), 32'(1));

    repeat (2 * A_HT * A_VT * A_DIV + 100) @(negedge clk);
    checkOutput("A.sof_period", 32'(per_a), 32'(A_HT * A_VT * A_DIV));
    checkOutput("B.sof_period", 32'(per_b), 32'(B_HT * B_VT * B_DIV));

    // Drop en mid-frame: the frame still completes, then the generator idles.
    n = 0;
    while (!(y_a == 6'd5) && n < 4000) begin @(negedge clk); n++; end
    checkOutput("A.reach_y5", 32'(y_a == 6'd5), 32'(1));
    en_a = 1'b0;
    fc_saved = fc_a;
    n = 0;
    while (!(x_a == 6'(A_HT - 1) && y_a == 6'(A_VT - 1)) && n < 4000) begin
      @(negedge clk); n++;
    end
    checkOutput("A.reach_frame_end", 32'(x_a == 6'(A_HT - 1) && y_a == 6'(A_VT - 1)), 32'(1));
    repeat (2 * A_DIV) @(negedge clk);
    checkOutput("A.idle_x", 32'(x_a), 32'(0));
    checkOutput("A.idle_hsync", 32'(hs_a), 32'(1));
    checkOutput("A.idle_fc_held", 32'(fc_a), 32'(fc_saved));
    repeat (20) @(negedge clk);
    en_a = 1'b1;
    n = 0;
    while (!sof_a && n < 4 * A_DIV) begin @(negedge clk); n++; end
    checkOutput("A.restart_sof", 32'(sof_a), 32'(1));
    checkOutput("A.restart_fc", 32'(fc_a), 32'(4'(fc_saved + 4'd1)));

    // Asynchronous reset while hsync is active mid-line.
    n = 0;
    while (!(x_a == 6'd21) && n < 4000) begin @(negedge clk); n++; end
    checkOutput("A.reach_x21", 32'(x_a == 6'd21), 32'(1));
    @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    checkOutput("A.rst_x", 32'(x_a), 32'(0));
    checkOutput("A.rst_y", 32'(y_a), 32'(0));
    checkOutput("A.rst_hsync", 32'(hs_a), 32'(1));
    checkOutput("A.rst_vsync", 32'(vs_a), 32'(1));
    checkOutput("A.rst_de", 32'(de_a), 32'(0));
    checkOutput("A.rst_pix_ce", 32'(ce_a), 32'(0));
    checkOutput("A.rst_fc", 32'(fc_a), 32'(0));
    @(negedge clk);
    rst_a = 1'b0;

    applyStimulus(12000);
    checkOutput("B.fc_wrap", 32'(fc_b), 32'(sof_b_cnt % 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
